id_stage_pipe: RTL and testbench

- Parametrised, registered MIPS instruction-decode stage.
- Contains the decode/control logic, a register file with `$0` hardwired to zero, sign extension, load-use hazard detection and the ID/EX pipeline register.
- Sits between the IF/ID register and the EX stage. Consumes the WB write-back port and produces a valid-tagged ID/EX bundle one cycle after the instruction is presented.

---
 rtl/id_stage_pipe.sv | 173 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: control decode, register file, sign extension,
// load-use hazard detection and ID/EX register. Optional macro: REGFILE_BYPASS_EN.
module id_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [31:0]       if_inst,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_alusrc,
    output logic              ex_regdst,
    output logic              ex_branch,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic [1:0]        ex_aluop
);

    localparam int unsigned NREG = 2 ** REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef struct packed {
        logic       alusrc;
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic [1:0] aluop;
    } ctrl_t;

    logic [5:0]        opcode_c;
    logic [REG_AW-1:0] rs_c;
    logic [REG_AW-1:0] rt_c;
    logic [REG_AW-1:0] rd_c;
    logic signed [15:0] imm16_c;
    logic [DATA_W-1:0] imm_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;
    logic              uses_rt_c;
    ctrl_t             ctrl_c;
    ctrl_t             ex_ctrl;
    logic [DATA_W-1:0] regs [NREG];

    assign opcode_c = if_inst[31:26];
    assign rs_c     = REG_AW'(if_inst[25:21]);
    assign rt_c     = REG_AW'(if_inst[20:16]);
    assign rd_c     = REG_AW'(if_inst[15:11]);
    assign imm16_c  = if_inst[15:0];
    assign imm_c    = DATA_W'(imm16_c);

    // Register file: $0 is never written and always reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd1_c = (rs_c == '0) ? '0 : regs[rs_c];
        rd2_c = (rt_c == '0) ? '0 : regs[rt_c];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && (wb_addr != '0) && (wb_addr == rs_c)) rd1_c = wb_data;
        if (wb_we && (wb_addr != '0) && (wb_addr == rt_c)) rd2_c = wb_data;
`endif
    end

    // Control decode by opcode; unknown opcodes decode to all-zero controls.
    always_comb begin
        ctrl_c    = '0;
        uses_rt_c = 1'b0;
        case (opcode_c)
            OP_RTYPE: begin
                ctrl_c.regdst   = 1'b1;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.aluop    = 2'b10;
                uses_rt_c       = 1'b1;
            end
            OP_LW: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.memread  = 1'b1;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.memtoreg = 1'b1;
            end
            OP_SW: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.memwrite = 1'b1;
                uses_rt_c       = 1'b1;
            end
            OP_BEQ: begin
                ctrl_c.branch = 1'b1;
                ctrl_c.aluop  = 2'b01;
                uses_rt_c     = 1'b1;
            end
            OP_ADDI: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Load-use: the load in EX targets a register this instruction reads.
    assign id_stall = if_valid & ex_valid & ex_ctrl.memread & (ex_rt != '0)
                    & ((ex_rt == rs_c) | ((ex_rt == rt_c) & uses_rt_c));

    // ID/EX register; flush and stall both insert a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else begin
            ex_pc  <= if_pc;
            ex_rd1 <= rd1_c;
            ex_rd2 <= rd2_c;
            ex_imm <= imm_c;
            ex_rs  <= rs_c;
            ex_rt  <= rt_c;
            ex_rd  <= rd_c;
            if (flush || id_stall) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
            end else begin
                ex_valid <= if_valid;
                ex_ctrl  <= if_valid ? ctrl_c : '0;
            end
        end
    end

    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_regdst   = ex_ctrl.regdst;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_id_stage_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = 32;
    localparam int unsigned NR = 32;

`ifdef REGFILE_BYPASS_EN
    localparam logic [DW-1:0] BYP_EXP = 32'h1234ABCD;
`else
    localparam logic [DW-1:0] BYP_EXP = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_valid = 1'b0;
    logic [PW-1:0] if_pc = '0;
    logic [31:0]   if_inst = '0;
    logic          flush = 1'b0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          id_stall, ex_valid;
    logic [PW-1:0] ex_pc;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
    logic [1:0]    ex_aluop;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .PC_W(PW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_branch(ex_branch),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop)
    );

    // Model state: architectural registers and the expected ID/EX contents.
    logic [DW-1:0] m_rf [NR];
    bit            m_valid;
    logic [8:0]    m_ctrl;   // {alusrc,regdst,branch,memread,memwrite,regwrite,memtoreg,aluop[1:0]}
    logic [PW-1:0] m_pc;
    logic [DW-1:0] m_rd1, m_rd2, m_imm;
    logic [AW-1:0] m_rs, m_rt, m_rd;
    bit            m_stall;
    bit            last_stall;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b0_1_0_0_0_1_0_10;
            6'h23:   return 9'b1_0_0_1_0_1_1_00;
            6'h2B:   return 9'b1_0_0_0_1_0_0_00;
            6'h04:   return 9'b0_0_1_0_0_0_0_01;
            6'h08:   return 9'b1_0_0_0_0_1_0_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_ctrl();
        return {ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite,
                ex_regwrite, ex_memtoreg, ex_aluop};
    endfunction

    task automatic check_outputs();
        check("ex_valid", 64'(ex_valid), 64'(m_valid));
        check("ex_ctrl", 64'(dut_ctrl()), 64'(m_ctrl));
        if (m_valid) begin
            check("ex_pc", 64'(ex_pc), 64'(m_pc));
            check("ex_rd1", 64'(ex_rd1), 64'(m_rd1));
            check("ex_rd2", 64'(ex_rd2), 64'(m_rd2));
            check("ex_imm", 64'(ex_imm), 64'(m_imm));
            check("ex_idx", 64'({ex_rs, ex_rt, ex_rd}), 64'({m_rs, m_rt, m_rd}));
        end
    endtask

    task automatic check_reset_state();
        check("rst_valid", 64'(ex_valid), 64'(0));
        check("rst_ctrl", 64'(dut_ctrl()), 64'(0));
        check("rst_data", 64'({ex_pc, ex_rd1}), 64'(0));
        check("rst_imm_rd2", 64'({ex_rd2, ex_imm}), 64'(0));
        check("rst_idx", 64'({ex_rs, ex_rt, ex_rd}), 64'(0));
        check("rst_stall", 64'(id_stall), 64'(0));
    endtask

    // One clock: drive at negedge, check stall, advance model at posedge, check outputs.
    task automatic cycle(input bit v, input logic [PW-1:0] pc, input logic [31:0] inst,
                         input bit fl, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic [5:0]    op;
        logic [AW-1:0] rs, rt;
        logic [DW-1:0] n_rd1, n_rd2, n_imm;
        bit            uses_rt;
        @(negedge clk);
        if_valid = v; if_pc = pc; if_inst = inst; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16];
        uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        m_stall = v && m_valid && m_ctrl[5] && (m_rt != 0) && (m_rt == rs || (m_rt == rt && uses_rt));
        check("id_stall", 64'(id_stall), 64'(m_stall));
        last_stall = id_stall;
        n_rd1 = m_read(rs);
        n_rd2 = m_read(rt);
        n_imm = inst[15] ? {16'hFFFF, inst[15:0]} : {16'h0000, inst[15:0]};
        @(posedge clk);
        if (fl || m_stall) begin
            m_valid = 1'b0; m_ctrl = '0;
        end else begin
            m_valid = v; m_ctrl = v ? ctrl_of(op) : 9'b0;
        end
        m_pc = pc; m_rd1 = n_rd1; m_rd2 = n_rd2; m_imm = n_imm;
        m_rs = rs; m_rt = rt; m_rd = inst[15:11];
        if (we && wa != 0) m_rf[wa] = wd;
        #1;
        check_outputs();
    endtask

    // Assert reset mid-cycle with random inputs; outputs must clear immediately.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #2;
        rst = 1'b0;
        if_valid = 1'($urandom_range(0, 1)); if_pc = $urandom(); if_inst = $urandom();
        flush = 1'($urandom_range(0, 1)); wb_we = 1'b1;
        wb_addr = AW'($urandom_range(1, NR - 1)); wb_data = $urandom();
        #1;
        check_reset_state();
        repeat (ncyc) @(posedge clk);
        #1;
        check_reset_state();
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        m_valid = 1'b0; m_ctrl = '0; m_stall = 1'b0;
        m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
        @(negedge clk);
        if_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
        rst = 1'b1;
    endtask

    logic [31:0]   cur_inst;
    logic [PW-1:0] cur_pc;
    bit            cur_v;
    bit            cur_fl;
    bit            hold;

    initial begin
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        do_reset(3);

        // Same-cycle write-back of r5 while add r3,r5,r6 decodes
        cycle(1, 32'h100, rtype(5, 6, 3), 0, 1, 5, 32'h1234ABCD);
        check("bypass_rd1", 64'(ex_rd1), 64'(BYP_EXP));
        check("add_fields", 64'({ex_rs, ex_rd, ex_regdst, ex_aluop}), 64'({5'd5, 5'd3, 1'b1, 2'b10}));
        cycle(1, 32'h104, rtype(5, 0, 8), 0, 0, 0, 0);
        check("r5_written", 64'(ex_rd1), 64'h1234ABCD);

        // Writes to $0 are dropped
        cycle(0, 32'h108, 32'h0, 0, 1, 0, 32'hFFFFFFFF);
        cycle(1, 32'h10C, rtype(0, 0, 1), 0, 0, 0, 0);
        check("r0_rd1_rd2", 64'({ex_rd1, ex_rd2}), 64'(0));

        // Load-use: lw r2,4(r1) then add r4,r2,r3 -> exactly one bubble
        cycle(1, 32'h110, itype(6'h23, 1, 2, 16'h0004), 0, 0, 0, 0);
        check("lw_ctrl", 64'({ex_alusrc, ex_memread, ex_regwrite, ex_memtoreg, ex_imm}), 64'({4'hF, 32'h4}));
        cycle(1, 32'h114, rtype(2, 3, 4), 0, 0, 0, 0);
        check("lu_stall", 64'(last_stall), 64'(1));
        check("lu_bubble", 64'(ex_valid), 64'(0));
        cycle(1, 32'h114, rtype(2, 3, 4), 0, 0, 0, 0);
        check("lu_release", 64'(last_stall), 64'(0));
        check("lu_issue", 64'({ex_valid, ex_regdst, ex_aluop, ex_pc}), 64'({1'b1, 1'b1, 2'b10, 32'h114}));

        // Flush coincident with stall, then sign-extended addi issues immediately
        cycle(1, 32'h118, itype(6'h23, 1, 2, 16'h0008), 0, 0, 0, 0);
        cycle(1, 32'h11C, rtype(2, 3, 4), 1, 0, 0, 0);
        check("fl_stall_seen", 64'(last_stall), 64'(1));
        check("fl_bubble", 64'({ex_valid, ex_regwrite}), 64'(0));
        cycle(1, 32'h200, itype(6'h08, 1, 7, 16'h8001), 0, 0, 0, 0);
        check("fl_no_extra", 64'({last_stall, ex_valid}), 64'(2'b01));
        check("sext_imm", 64'(ex_imm), 64'hFFFF8001);
        check("addi_ctrl", 64'({ex_alusrc, ex_regwrite, ex_rt}), 64'({1'b1, 1'b1, 5'd7}));

        // Unknown opcode: valid but no controls
        cycle(1, 32'h204, itype(6'h3F, 1, 2, 16'h1234), 0, 0, 0, 0);
        check("unk_op", 64'({ex_valid, dut_ctrl()}), 64'({1'b1, 9'b0}));

        do_reset(2);

        // Randomized traffic; upstream re-presents the instruction while stalled
        cur_inst = 32'h0; cur_pc = '0; cur_v = 1'b0; cur_fl = 1'b0;
        for (int n = 0; n < 800; n++) begin
            hold = m_stall && !cur_fl;
            if (!hold) begin
                cur_inst = $urandom();
                case ($urandom_range(0, 5))
                    0: cur_inst[31:26] = 6'h00;
                    1: cur_inst[31:26] = 6'h23;
                    2: cur_inst[31:26] = 6'h2B;
                    3: cur_inst[31:26] = 6'h04;
                    4: cur_inst[31:26] = 6'h08;
                    default: ;
                endcase
                cur_inst[25:21] = 5'($urandom_range(0, 7));
                cur_inst[20:16] = 5'($urandom_range(0, 7));
                cur_pc = $urandom();
                cur_v  = ($urandom_range(0, 99) < 85);
            end
            cur_fl = ($urandom_range(0, 99) < 10);
            cycle(cur_v, cur_pc, cur_inst, cur_fl, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), $urandom());
            if (n == 400) do_reset(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
